// File: rtl/logic_unit_pkg.sv
// Shared op codes, op field width and pipeline state encoding for the logic unit.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  // Encoding is {main_v, skid_v}; 2'b01 is illegal and never produced.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise logic over WIDTH bits; unknown op codes fall back to PASS.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with main + skid storage and valid/ready on both sides.
// Define LOGIC_UNIT_FLAGS_EN to add out_zero / out_parity aligned with out_data.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] txn_count
);

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int unsigned EntW = WIDTH + 2;
`else
  localparam int unsigned EntW = WIDTH;
`endif

  state_e           state_q;
  logic [EntW-1:0]  main_q;
  logic [EntW-1:0]  skid_q;
  logic [EntW-1:0]  new_entry;
  logic [WIDTH-1:0] result;
  logic             in_ready_q;
  logic [CNT_W-1:0] txn_count_q;
  logic             accept;
  logic             emit;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (result)
  );

`ifdef LOGIC_UNIT_FLAGS_EN
  assign new_entry  = {^result, ~|result, result};
  assign out_parity = main_q[WIDTH+1];
  assign out_zero   = main_q[WIDTH];
`else
  assign new_entry = result;
`endif

  assign out_valid = state_q[1];
  assign out_data  = main_q[WIDTH-1:0];
  assign in_ready  = in_ready_q;
  assign txn_count = txn_count_q;
  assign accept    = in_valid && in_ready_q;
  assign emit      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      txn_count_q <= '0;
    end else begin
      if (emit && (txn_count_q != '1)) begin
        txn_count_q <= txn_count_q + CNT_W'(1);
      end
      // in_ready_q tracks !skid_v of the next state; only a full skid clears it.
      in_ready_q <= 1'b1;
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= new_entry;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && emit) begin
            main_q <= new_entry;
          end else if (accept) begin
            skid_q     <= new_entry;
            state_q    <= StFull;
            in_ready_q <= 1'b0;
          end else if (emit) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (emit) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe; flag checks compile in with LOGIC_UNIT_FLAGS_EN.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [15:0] txn_count;
  logic       in_ready_s;
  logic       out_valid_s;
  logic [7:0] out_data_s;
  logic [1:0] txn_count_s;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic       out_zero, out_parity, out_zero_s, out_parity_s;
`endif

  int checks = 0;
  int failures = 0;
  int emits = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero  (out_zero),
    .out_parity(out_parity),
`endif
    .txn_count (txn_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data_s),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero  (out_zero_s),
    .out_parity(out_parity_s),
`endif
    .txn_count (txn_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // Handshakes are resolved at the negedge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          check("sb_data", {24'd0, out_data}, {24'd0, exp});
`ifdef LOGIC_UNIT_FLAGS_EN
          check("sb_zero", {31'd0, out_zero}, {31'd0, (exp == 8'd0)});
          check("sb_parity", {31'd0, out_parity}, {31'd0, ^exp});
`endif
          emits++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_op, in_a, in_b));
    end
  end

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high so back-to-back calls stream with no idle cycle.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sweep_exp [8];
    time t0;
    int e0;
    sweep_exp = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};

    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_txn", {16'd0, txn_count}, 32'd0);
    do_reset();
    check("ready_after_release", {31'd0, in_ready}, 32'd1);

    // NOT with one-cycle latency
    out_ready = 1'b1;
    send(3'd0, 8'b10101010, 8'h00);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("not_1", {24'd0, out_data}, 32'h55);
    send(3'd0, 8'b11001100, 8'h00);
    check("not_2", {24'd0, out_data}, 32'h33);
    drain();

    // Op sweep
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(i[2:0], 8'hF0, 8'hCC);
      check($sformatf("sweep_op%0d", i), {24'd0, out_data}, {24'd0, sweep_exp[i]});
    end
    drain();
    check("sweep_txn", {16'd0, txn_count}, 32'd8);

    // Saturating counter on the CNT_W=2 instance
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(3'd7, 8'(i + 1), 8'h00);
    drain();
    check("sat_txn_small", {30'd0, txn_count_s}, 32'd3);
    check("sat_txn_main", {16'd0, txn_count}, 32'd5);

    // Backpressure: two accepted, third held
    do_reset();
    out_ready = 1'b0;
    send(3'd7, 8'h01, 8'h00);
    send(3'd7, 8'h02, 8'h00);
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    in_a = 8'h03;
    in_b = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("bp_still_full", {31'd0, in_ready}, 32'd0);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_data", {24'd0, out_data}, 32'h01);
    in_b = 8'h5A;
    e0 = emits;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_out2", {24'd0, out_data}, 32'h02);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_out3", {24'd0, out_data}, 32'h03);
    check("bp_out3_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_no_gap", emits - e0, 32'd3);
    drain();

    // Continuous streaming
    do_reset();
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 20; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    check("stream_cycles", 32'(($time - t0) / 10), 32'd20);
    drain();
    check("stream_txn", {16'd0, txn_count}, 32'd20);

    // Asynchronous reset while FULL
    do_reset();
    out_ready = 1'b1;
    send(3'd1, 8'h3C, 8'h0F);
    drain();
    out_ready = 1'b0;
    send(3'd2, 8'h11, 8'h22);
    send(3'd3, 8'h44, 8'h0F);
    in_valid = 1'b0;
    check("full_before_rst", {31'd0, in_ready}, 32'd0);
    check("txn_before_rst", {16'd0, txn_count}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_txn", {16'd0, txn_count}, 32'd0);
    check("arst_out_data", {24'd0, out_data}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    e0 = emits;
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_stale_valid", {31'd0, out_valid}, 32'd0);
    check("arst_no_stale_emit", emits - e0, 32'd0);
    check("arst_txn_after", {16'd0, txn_count}, 32'd0);

`ifdef LOGIC_UNIT_FLAGS_EN
    send(3'd3, 8'hAA, 8'hAA);
    check("flag_xor_data", {24'd0, out_data}, 32'd0);
    check("flag_xor_zero", {31'd0, out_zero}, 32'd1);
    check("flag_xor_par", {31'd0, out_parity}, 32'd0);
    send(3'd7, 8'h07, 8'h00);
    check("flag_pass_zero", {31'd0, out_zero}, 32'd0);
    check("flag_pass_par", {31'd0, out_parity}, 32'd1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit; generalises the team's combinational inverter to eight selectable bitwise ops on WIDTH-bit operands.
- Sits between producer and consumer datapaths with valid/ready handshakes on both sides.
- Has a 1-cycle result register plus a skid register, so in_ready is a registered signal.
- Keeps a saturating count of completed transactions for debug.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the transaction counter.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, reset, asynchronous assert, active-low.
- in_valid, in, 1, producer has a transaction.
- in_ready, out, 1, unit can accept a transaction.
- in_op, in, 3, operation code.
- in_a, in, WIDTH, operand A.
- in_b, in, WIDTH, operand B (ignored by NOT and PASS).
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts the result.
- out_data, out, WIDTH, result.
- txn_count, out, CNT_W, number of output handshakes, saturating.

Behaviour:
- Op codes:
  - 0 NOT: ~a
  - 1 AND
  - 2 OR
  - 3 XOR
  - 4 NAND
  - 5 NOR
  - 6 XNOR
  - 7 PASS: a
- Accept occurs when in_valid && in_ready on a clk edge. Emit occurs when out_valid && out_ready.
- Reset (rst_n low, asynchronous): all of the following take effect immediately and hold while rst_n is low:
  - out_valid = 0, out_data = 0, txn_count = 0.
  - skid register empty.
  - in_ready = 0 during reset; in_ready = 1 on the first clk edge after release.
- Storage is a main register (drives out_*) and a skid register. State = {main_v, skid_v}, legal values EMPTY(00), ONE(10), FULL(11).
  - in_ready = !skid_v, registered.
  - out_valid = main_v.
- Transitions:
  - EMPTY: accept → ONE with the result in main.
  - ONE, accept & emit: main takes the new result; stays ONE.
  - ONE, accept & no emit: new result goes to skid → FULL.
  - ONE, emit only → EMPTY.
  - FULL: no accept possible. Emit: skid moves to main → ONE.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1 when main was empty or emitted in N.
- Throughput: 1 transaction per cycle when out_ready is held high.
- Ordering: strictly FIFO. The skid entry is never emitted ahead of main.
- Hold rule: out_data and out_valid hold stable while out_valid && !out_ready.
- Compute timing: the result is computed from in_op, in_a and in_b at accept time and stored. Later input changes never alter stored results.
- Width rule: all ops are bitwise over WIDTH bits, with no carries and no extension.
- txn_count:
  - Increments by 1 on every emit.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-operation: stored results in main and skid are discarded with no output. txn_count returns to 0.
- An illegal state (01) is unreachable. If it is ever detected, the unit recovers to EMPTY.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN.
- Defined: adds outputs out_zero (result == 0) and out_parity (XOR-reduce of result).
  - Both are stored alongside the result in main and skid and are aligned with out_data.
  - Reset value 0.
- Not defined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package/include logic_unit_pkg holds:
  - op-code constants OP_NOT..OP_PASS.
  - op field width 3.
- One combinational sub-module, logic_unit_core:
  - Parameter WIDTH; inputs op, a, b; output result.
  - Pure case on op; default → PASS.
- logic_unit_pipe instantiates logic_unit_core and holds the skid/handshake logic and counter.

Test Plan:
- Reset, then out_ready=1; send op=0, a=8'b10101010 → next cycle out_valid=1, out_data=8'b01010101. Then op=0, a=8'b11001100 → out_data=8'b00110011.
- Sweep all 8 ops with a=8'hF0, b=8'hCC → results in order:
  - NOT 0F, AND C0, OR FC, XOR 3C, NAND 3F, NOR 03, XNOR C3, PASS F0.
  - txn_count=8.
- Backpressure: out_ready=0, stream a=01,02,03 with op=7 →
  - Accepts 01 and 02; in_ready=0 after the second accept; 03 is held.
  - Then out_ready=1 → outputs 01,02,03 in order, with no gaps after the first.
- Continuous in_valid=1 and out_ready=1 for 20 cycles → 20 results on consecutive cycles, in_ready stays 1, txn_count=20.
- Assert rst_n=0 mid-cycle while FULL → out_valid=0 and txn_count=0 immediately, without waiting for a clk edge. After release, no stale data is emitted.
- CNT_W=2: run 5 transactions → txn_count=3 (saturated).
- With LOGIC_UNIT_FLAGS_EN:
  - a=8'hAA, op=3, b=8'hAA → out_data=0, out_zero=1, out_parity=0.
  - a=8'h07, op=7 → out_zero=0, out_parity=1.
